// File: rtl/tri_raster_ctrl.sv
// Bounding-box rasteriser: scans every pixel of a triangle's box in row-major order and
// flags inside/outside using one shared edge-function unit evaluated over three cycles.
module tri_raster_ctrl #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] p1x,
    input  logic [W-1:0] p1y,
    input  logic [W-1:0] p2x,
    input  logic [W-1:0] p2y,
    input  logic [W-1:0] p3x,
    input  logic [W-1:0] p3y,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_x,
    output logic [W-1:0] out_y,
    output logic         out_inside,
    output logic         done,
    output logic [2:0]   dbg_state
);

    // Stream handshake: a pixel transfers on a rising edge where out_valid && out_ready;
    // out_valid and the pixel fields hold unchanged until that transfer happens.

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_BBOX = 3'd1,
        S_EDGE = 3'd2,
        S_EMIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    state_t         state_q;
    logic [W-1:0]   v1x_q, v1y_q, v2x_q, v2y_q, v3x_q, v3y_q;
    logic [W-1:0]   xmin_q, xmax_q, ymin_q, ymax_q;
    logic [W-1:0]   cur_x_q, cur_y_q;
    logic [1:0]     e_q;
    logic [1:0]     sign_q;
    logic           busy_q, valid_q, inside_q, done_q;
    logic [W-1:0]   ox_q, oy_q;

    logic [W-1:0]          ax, ay, bx, by;
    logic signed [W:0]     dpx, day, dax, dpy;
    logic signed [2*W+1:0] prod_a, prod_b;
    logic signed [2*W+2:0] edge_d;
    logic                  sign_now;

    function automatic logic [W-1:0] min3(input logic [W-1:0] a, b, c);
        logic [W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [W-1:0] max3(input logic [W-1:0] a, b, c);
        logic [W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Edge e uses (p1,p2), (p2,p3), (p3,p1); operands widened so d cannot overflow.
    always_comb begin
        ax = v1x_q;
        ay = v1y_q;
        bx = v2x_q;
        by = v2y_q;
        case (e_q)
            2'd1: begin ax = v2x_q; ay = v2y_q; bx = v3x_q; by = v3y_q; end
            2'd2: begin ax = v3x_q; ay = v3y_q; bx = v1x_q; by = v1y_q; end
            default: ;
        endcase
        dpx      = $signed({1'b0, cur_x_q}) - $signed({1'b0, bx});
        day      = $signed({1'b0, ay}) - $signed({1'b0, by});
        dax      = $signed({1'b0, ax}) - $signed({1'b0, bx});
        dpy      = $signed({1'b0, cur_y_q}) - $signed({1'b0, by});
        prod_a   = (2*W+2)'(dpx) * (2*W+2)'(day);
        prod_b   = (2*W+2)'(dax) * (2*W+2)'(dpy);
        edge_d   = (2*W+3)'(prod_a) - (2*W+3)'(prod_b);
        sign_now = edge_d[2*W+2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            v1x_q    <= '0; v1y_q <= '0; v2x_q <= '0;
            v2y_q    <= '0; v3x_q <= '0; v3y_q <= '0;
            xmin_q   <= '0; xmax_q <= '0; ymin_q <= '0; ymax_q <= '0;
            cur_x_q  <= '0; cur_y_q <= '0;
            e_q      <= '0;
            sign_q   <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            inside_q <= 1'b0;
            done_q   <= 1'b0;
            ox_q     <= '0;
            oy_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        v1x_q   <= p1x; v1y_q <= p1y;
                        v2x_q   <= p2x; v2y_q <= p2y;
                        v3x_q   <= p3x; v3y_q <= p3y;
                        busy_q  <= 1'b1;
                        state_q <= S_BBOX;
                    end
                end
                S_BBOX: begin
                    xmin_q  <= min3(v1x_q, v2x_q, v3x_q);
                    xmax_q  <= max3(v1x_q, v2x_q, v3x_q);
                    ymin_q  <= min3(v1y_q, v2y_q, v3y_q);
                    ymax_q  <= max3(v1y_q, v2y_q, v3y_q);
                    cur_x_q <= min3(v1x_q, v2x_q, v3x_q);
                    cur_y_q <= min3(v1y_q, v2y_q, v3y_q);
                    e_q     <= 2'd0;
                    state_q <= S_EDGE;
                end
                S_EDGE: begin
                    if (e_q == 2'd2) begin
                        inside_q <= (sign_q[0] == sign_q[1]) && (sign_q[1] == sign_now);
                        ox_q     <= cur_x_q;
                        oy_q     <= cur_y_q;
                        valid_q  <= 1'b1;
                        state_q  <= S_EMIT;
                    end else begin
                        sign_q[e_q[0]] <= sign_now;
                        e_q            <= e_q + 2'd1;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        e_q     <= 2'd0;
                        if (cur_x_q < xmax_q) begin
                            cur_x_q <= cur_x_q + ONE;
                            state_q <= S_EDGE;
                        end else if (cur_y_q < ymax_q) begin
                            cur_x_q <= xmin_q;
                            cur_y_q <= cur_y_q + ONE;
                            state_q <= S_EDGE;
                        end else begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign out_valid  = valid_q;
    assign out_x      = ox_q;
    assign out_y      = oy_q;
    assign out_inside = inside_q;
    assign done       = done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_tri_raster_ctrl.sv
// Bench for tri_raster_ctrl: table of triangles with a reference pixel model feeding an
// expected-pixel queue, plus hand-written reset-abort and busy-start sequences.
module tb_tri_raster_ctrl;

    localparam int W = 11;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] p1x, p1y, p2x, p2y, p3x, p3y;
    logic         busy, out_valid, out_ready, out_inside, done;
    logic [W-1:0] out_x, out_y;
    logic [2:0]   dbg_state;

    tri_raster_ctrl #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y), .p3x(p3x), .p3y(p3y),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_inside(out_inside),
        .done(done), .dbg_state(dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int x1, y1, x2, y2, x3, y3;
        int mode;        // 0: ready always high, 1: ready pattern 1,0,0
        bit busy_pulse;
        bit spots;
        int exp_n;       // -1: take pixel count from the model
        int exp_done;    // -1: 4N+2 plus observed stall cycles
    } tc_t;

    tc_t tbl[6];

    logic [2*W:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int edge_d(input int px, py, ax, ay, bx, by);
        return (px - bx) * (ay - by) - (ax - bx) * (py - by);
    endfunction

    // Reference model: pushes every box pixel {x, y, inside} in row-major order.
    function automatic int push_model(input int x1, y1, x2, y2, x3, y3);
        int xmin, xmax, ymin, ymax, n;
        bit s0, s1, s2;
        logic [W-1:0] xs, ys;
        xmin = x1; if (x2 < xmin) xmin = x2; if (x3 < xmin) xmin = x3;
        xmax = x1; if (x2 > xmax) xmax = x2; if (x3 > xmax) xmax = x3;
        ymin = y1; if (y2 < ymin) ymin = y2; if (y3 < ymin) ymin = y3;
        ymax = y1; if (y2 > ymax) ymax = y2; if (y3 > ymax) ymax = y3;
        n = 0;
        for (int y = ymin; y <= ymax; y++) begin
            for (int x = xmin; x <= xmax; x++) begin
                s0 = edge_d(x, y, x1, y1, x2, y2) < 0;
                s1 = edge_d(x, y, x2, y2, x3, y3) < 0;
                s2 = edge_d(x, y, x3, y3, x1, y1) < 0;
                xs = x[W-1:0];
                ys = y[W-1:0];
                exp_q.push_back({xs, ys, (s0 == s1) && (s1 == s2)});
                n++;
            end
        end
        return n;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   32'(busy), 32'd0);
        check({tag, "_valid"},  32'(out_valid), 32'd0);
        check({tag, "_x"},      32'(out_x), 32'd0);
        check({tag, "_y"},      32'(out_y), 32'd0);
        check({tag, "_inside"}, 32'(out_inside), 32'd0);
        check({tag, "_done"},   32'(done), 32'd0);
        check({tag, "_state"},  32'(dbg_state), 32'd0);
    endtask

    task automatic drive_start(input tc_t tc);
        start = 1'b1;
        p1x = tc.x1[W-1:0]; p1y = tc.y1[W-1:0];
        p2x = tc.x2[W-1:0]; p2y = tc.y2[W-1:0];
        p3x = tc.x3[W-1:0]; p3y = tc.y3[W-1:0];
    endtask

    task automatic run_case(input tc_t tc, input string tag);
        int n_exp, seen, stalls, cyc, done_cyc, stall_err, overlap, exp_d;
        bit got_done, hold_v;
        logic [2*W:0] held, got, e;
        n_exp = push_model(tc.x1, tc.y1, tc.x2, tc.y2, tc.x3, tc.y3);
        if (tc.exp_n >= 0) n_exp = tc.exp_n;
        seen = 0; stalls = 0; cyc = 0; done_cyc = 0; stall_err = 0; overlap = 0;
        got_done = 0; hold_v = 0; held = '0;
        @(negedge clk);
        drive_start(tc);
        out_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (!got_done && cyc < 10 * n_exp + 50) begin
            @(negedge clk);
            cyc++;
            got = {out_x, out_y, out_inside};
            if (hold_v) begin
                if (!out_valid || got !== held) stall_err++;
                hold_v = 0;
            end
            if (done && out_valid) overlap++;
            if (cyc == 1) check({tag, "_busy_bbox"}, 32'(busy), 32'd1);
            if (tc.busy_pulse && cyc == 7) begin
                start = 1'b1;
                p1x = 11'd100; p1y = 11'd100; p2x = 11'd300;
                p2y = 11'd100; p3x = 11'd100; p3y = 11'd300;
            end
            if (tc.busy_pulse && cyc == 8) start = 1'b0;
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
                check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
            end else if (out_valid) begin
                out_ready = (tc.mode == 0) ? 1'b1 : ((cyc % 3) == 1);
                if (out_ready) begin
                    seen++;
                    if (exp_q.size() == 0) begin
                        check({tag, "_extra_pixel"}, 32'(got), 32'hffffffff);
                    end else begin
                        e = exp_q.pop_front();
                        check({tag, "_pixel"}, 32'(got), 32'(e));
                    end
                    if (tc.spots && out_x == 11'd1 && out_y == 11'd1)
                        check({tag, "_spot_1_1"}, 32'(out_inside), 32'd1);
                    if (tc.spots && out_x == 11'd4 && out_y == 11'd4)
                        check({tag, "_spot_4_4"}, 32'(out_inside), 32'd0);
                    if (tc.spots && out_x == 11'd0 && out_y == 11'd0)
                        check({tag, "_spot_0_0"}, 32'(out_inside), 32'd1);
                end else begin
                    stalls++;
                    hold_v = 1;
                    held = got;
                end
            end else begin
                out_ready = (tc.mode == 0) ? 1'b1 : ((cyc % 3) == 1);
            end
        end
        exp_d = (tc.exp_done > 0) ? tc.exp_done : 4 * n_exp + 2 + stalls;
        check({tag, "_done_seen"}, 32'(got_done), 32'd1);
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_d));
        check({tag, "_pixel_count"}, 32'(seen), 32'(n_exp));
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_stall_stable"}, 32'(stall_err), 32'd0);
        check({tag, "_done_valid_overlap"}, 32'(overlap), 32'd0);
        if (tc.mode == 1) check({tag, "_stalls_seen"}, 32'(stalls > 0), 32'd1);
        exp_q.delete();
        @(negedge clk);
        check({tag, "_done_width"}, 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    endtask

    task automatic reset_mid_scan(input tc_t tc);
        int n, seen, cyc, done_hits;
        n = push_model(tc.x1, tc.y1, tc.x2, tc.y2, tc.x3, tc.y3);
        seen = 0; cyc = 0; done_hits = 0;
        @(negedge clk);
        drive_start(tc);
        out_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (seen < 9 && cyc < 10 * n) begin
            @(negedge clk);
            cyc++;
            if (out_valid) seen++;
        end
        check("rst_nine_pixels", 32'(seen), 32'd9);
        repeat (2) @(negedge clk);
        check("rst_in_edge_state", 32'(dbg_state), 32'd2);
        rst_n = 1'b0;
        #1 check_reset_outputs("rst_async");
        repeat (4) begin
            @(negedge clk);
            if (done || out_valid) done_hits++;
        end
        check("rst_no_done_no_pixel", 32'(done_hits), 32'd0);
        exp_q.delete();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; out_ready = 1'b0;
        p1x = '0; p1y = '0; p2x = '0; p2y = '0; p3x = '0; p3y = '0;

        tbl[0] = '{x1: 0, y1: 0, x2: 4, y2: 0, x3: 0, y3: 4, mode: 0, busy_pulse: 0, spots: 1, exp_n: 25, exp_done: 102};
        tbl[1] = '{x1: 7, y1: 9, x2: 7, y2: 9, x3: 7, y3: 9, mode: 0, busy_pulse: 0, spots: 0, exp_n: 1, exp_done: 6};
        tbl[2] = '{x1: 0, y1: 0, x2: 4, y2: 0, x3: 0, y3: 4, mode: 1, busy_pulse: 0, spots: 1, exp_n: 25, exp_done: -1};
        tbl[3] = '{x1: 0, y1: 0, x2: 4, y2: 0, x3: 0, y3: 4, mode: 0, busy_pulse: 1, spots: 1, exp_n: 25, exp_done: 102};
        tbl[4] = '{x1: 2045, y1: 2046, x2: 2047, y2: 2046, x3: 2047, y3: 2047, mode: 0, busy_pulse: 0, spots: 0, exp_n: 6, exp_done: 26};
        tbl[5] = '{x1: 0, y1: 0, x2: 0, y2: 0, x3: 0, y3: 0, mode: 0, busy_pulse: 0, spots: 0, exp_n: -1, exp_done: -1};
        tbl[5].x1 = 500 + $urandom_range(0, 6); tbl[5].y1 = 900 + $urandom_range(0, 6);
        tbl[5].x2 = 500 + $urandom_range(0, 6); tbl[5].y2 = 900 + $urandom_range(0, 6);
        tbl[5].x3 = 500 + $urandom_range(0, 6); tbl[5].y3 = 900 + $urandom_range(0, 6);

        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_case(tbl[i], $sformatf("case%0d", i));
        end

        reset_mid_scan(tbl[0]);
        run_case(tbl[0], "after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
